serial_char_rx: RTL and testbench
=================================

Name: serial_char_rx

Overview:
- UART-style 8N1 serial receiver; upstream character source for the identifier-checking FSM.
- Deserialises an asynchronous serial line into 8-bit ASCII characters.
- Presents each character as a held byte plus a one-cycle valid strobe, so the downstream identifier FSM sees one character per received frame.
- Flags malformed frames and never forwards them.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal values are even and ≥4.
- CNT_W, 8, width of the intra-bit cycle counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- rxd  input  1  serial line; idle high, asynchronous to clk.
- char  output  8  last correctly received byte; held between frames.
- char_valid  output  1  one-cycle pulse; char is new this cycle.
- frame_err  output  1  one-cycle pulse; stop bit was sampled low.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; char=8'h00; char_valid=0; frame_err=0; busy=0.
  - Both synchroniser flops reset to 1; counters reset to 0; shift register reset to 0.
- Reset asserted mid-frame aborts the frame immediately. No valid or error pulse is produced for it.
- Input sync: rxd passes through 2 flops → rxd_s. All decisions use rxd_s only.
- Counters:
  - cnt (CNT_W bits) counts cycles within a bit.
  - bit_idx (3 bits) counts data bits 0..7.
- IDLE:
  - cnt=0, bit_idx=0.
  - rxd_s==0 → START.
- START:
  - cnt increments each cycle.
  - At cnt==CLKS_PER_BIT/2-1 (mid start bit), sample rxd_s and set cnt=0.
  - Sample 0 → DATA.
  - Sample 1 → IDLE (glitch rejected; no output).
- DATA:
  - cnt increments; at cnt==CLKS_PER_BIT-1, sample rxd_s and set cnt=0.
  - Sampled bit shifts into the shift register LSB-first (bit 0 received first).
  - bit_idx increments. After the sample with bit_idx==7 → STOP.
- STOP:
  - At cnt==CLKS_PER_BIT-1, sample rxd_s.
  - Sample 1 → IDLE. Next cycle: char=shift register and char_valid=1.
  - Sample 0 → BREAK. Next cycle: frame_err=1. char is unchanged and char_valid stays 0.
- BREAK:
  - Wait until rxd_s==1, then → IDLE.
  - A continuously low line yields exactly one frame_err and no further frames.
- Pulse rules:
  - char_valid and frame_err are never high together.
  - Each is high for exactly one cycle per frame.
- Latency: char_valid rises 2 (sync) + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 1 cycles after the rxd falling edge, ±1 cycle of sync uncertainty.
- Back-to-back frames: a start bit arriving immediately after the stop-bit sample must be accepted. IDLE checks rxd_s on the first cycle after STOP.
- char holds its value across glitches, errors and idle periods. It changes only together with char_valid.
- busy=0 only in IDLE.
- No data is buffered. Only the most recent good byte is retained.

Test Plan:
Use CLKS_PER_BIT=4 for every scenario.
- Reset, rxd held 1 for 100 cycles → char=8'h00, char_valid and frame_err never asserted, busy=0.
- One frame 0x61 ('a') with stop=1 → exactly one char_valid pulse with char=8'h61; frame_err stays 0; char still 8'h61 50 cycles later.
- rxd low for 1 cycle only (shorter than half a bit), then high → no char_valid, no frame_err, busy returns to 0.
- Frame 0x39 ('9') with stop bit driven 0 and rxd held low for 60 cycles, then high:
  - exactly one frame_err pulse;
  - char keeps its previous value;
  - a following good frame 0x7A yields char=8'h7A.
- Back-to-back frames "x","1","?" (0x78, 0x31, 0x3F) with no idle gap → three char_valid pulses, in order, with the matching char values.
- rst_n pulsed low during DATA of frame 0x41, then a clean frame 0x42 → no pulse for 0x41; a single char_valid with char=8'h42.

Source files
------------

// File: rtl/serial_char_rx.sv
// ---------------------------------------------------------------------------
// serial_char_rx
// UART-style 8N1 serial receiver. It turns an asynchronous serial line into
// 8-bit characters for the downstream identifier-checking FSM. Each good frame
// produces one character with a one-cycle valid strobe. A frame whose stop bit
// is sampled low is flagged with a one-cycle error strobe and is not forwarded.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (even, >= 4)
//   CNT_W         width of the intra-bit counter (2**CNT_W > CLKS_PER_BIT)
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   rst_n       asynchronous active-low reset
//   rxd         serial line, idle high, asynchronous to clk
//   char        last correctly received byte, held between frames
//   char_valid  one-cycle pulse, char is new this cycle
//   frame_err   one-cycle pulse, stop bit was sampled low
//   busy        high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module serial_char_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] char,
    output logic       char_valid,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shreg, shreg_n;
    logic [7:0]       char_n;
    logic             char_valid_n;
    logic             frame_err_n;
    logic             rxd_meta;
    logic             rxd_s;

    // Two-flop synchroniser for the asynchronous line. Both flops reset to the
    // idle level so that leaving reset cannot look like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
        end
    end

    // State and datapath registers. The strobes are registered so they appear
    // on the cycle after the stop-bit sample, together with the new char.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            char       <= '0;
            char_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_idx_n;
            shreg      <= shreg_n;
            char       <= char_n;
            char_valid <= char_valid_n;
            frame_err  <= frame_err_n;
        end
    end

    // Next-state and datapath logic. The start bit is re-checked at its middle
    // so short glitches fall back to IDLE; data and stop bits are sampled one
    // full bit period apart after that point.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        bit_idx_n    = bit_idx;
        shreg_n      = shreg;
        char_n       = char;
        char_valid_n = 1'b0;
        frame_err_n  = 1'b0;

        case (state)
            IDLE: begin
                cnt_n     = '0;
                bit_idx_n = '0;
                if (!rxd_s) begin
                    state_n = START;
                end
            end

            START: begin
                if (cnt == HALF_M1) begin
                    cnt_n   = '0;
                    state_n = rxd_s ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_n     = '0;
                    shreg_n   = {rxd_s, shreg[7:1]};
                    bit_idx_n = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            STOP: begin
                if (cnt == FULL_M1) begin
                    cnt_n = '0;
                    if (rxd_s) begin
                        state_n      = IDLE;
                        char_n       = shreg;
                        char_valid_n = 1'b1;
                    end else begin
                        state_n     = BREAK;
                        frame_err_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            BREAK: begin
                cnt_n = '0;
                if (rxd_s) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_char_rx.sv
// ---------------------------------------------------------------------------
// tb_serial_char_rx
// Directed bench for serial_char_rx with CLKS_PER_BIT=4. Good frames push
// their byte onto a scoreboard queue; a monitor pops and compares on every
// char_valid pulse and keeps running counts of both strobes.
// ---------------------------------------------------------------------------
module tb_serial_char_rx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rxd;
    logic [7:0] char;
    logic       char_valid;
    logic       frame_err;
    logic       busy;

    int         errors      = 0;
    int         checks      = 0;
    int         cycle       = 0;
    int         cvCount     = 0;
    int         feCount     = 0;
    int         lastCvCycle = -1;
    int         startCycle  = 0;
    logic [7:0] sb[$];
    logic [7:0] prevChar    = 8'h00;

    serial_char_rx #(
        .CLKS_PER_BIT(CPB),
        .CNT_W       (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxd       (rxd),
        .char      (char),
        .char_valid(char_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    // Free-running clock and cycle counter used for latency measurement.
    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // Single comparison point: counts every check and reports failures.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives the first nbits of an 8N1 frame, LSB first, one bit per CPB cycles.
    task automatic driveFrame(input logic [7:0] d, input logic stopBit, input int nbits);
        logic [9:0] f;
        f = {stopBit, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            rxd = f[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    // Full frame; a good stop bit means the byte must come out of the DUT.
    task automatic applyStimulus(input logic [7:0] d, input logic stopBit);
        if (stopBit) sb.push_back(d);
        driveFrame(d, stopBit, 10);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (char_valid || frame_err)
                checkOutput("pulse_exclusive", 32'(char_valid & frame_err), 32'd0);
            if (char_valid) begin
                cvCount++;
                lastCvCycle = cycle;
                checkOutput("sb_nonempty", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) checkOutput("char_value", 32'(char), 32'(sb.pop_front()));
            end
            if (frame_err) feCount++;
            if (char !== prevChar && !char_valid)
                checkOutput("char_hold", 32'(char), 32'(prevChar));
        end
        prevChar = char;
    end

    initial begin
        rxd   = 1'b1;
        rst_n = 1'b0;
        waitCycles(3);
        checkOutput("reset_char", 32'(char), 32'h00);
        checkOutput("reset_valid", 32'(char_valid), 32'd0);
        checkOutput("reset_ferr", 32'(frame_err), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // Idle line for 100 cycles.
        waitCycles(100);
        checkOutput("idle_cv", cvCount, 0);
        checkOutput("idle_fe", feCount, 0);
        checkOutput("idle_char", 32'(char), 32'h00);
        checkOutput("idle_busy", 32'(busy), 32'd0);

        // Single good frame 'a'.
        startCycle = cycle;
        applyStimulus(8'h61, 1'b1);
        checkOutput("busy_in_stop", 32'(busy), 32'd1);
        waitCycles(10);
        checkOutput("a_cv", cvCount, 1);
        checkOutput("a_fe", feCount, 0);
        checkOutput("a_sb_empty", sb.size(), 0);
        checkOutput("a_latency", 32'((lastCvCycle - startCycle) >= 40 &&
                                     (lastCvCycle - startCycle) <= 42), 32'd1);
        waitCycles(50);
        checkOutput("a_held", 32'(char), 32'h61);

        // One-cycle glitch must be rejected.
        rxd = 1'b0;
        waitCycles(1);
        rxd = 1'b1;
        waitCycles(20);
        checkOutput("glitch_cv", cvCount, 1);
        checkOutput("glitch_fe", feCount, 0);
        checkOutput("glitch_busy", 32'(busy), 32'd0);
        checkOutput("glitch_char", 32'(char), 32'h61);

        // Bad stop bit, line held low, then a good frame.
        driveFrame(8'h39, 1'b0, 10);
        waitCycles(60);
        rxd = 1'b1;
        waitCycles(20);
        checkOutput("err_fe", feCount, 1);
        checkOutput("err_cv", cvCount, 1);
        checkOutput("err_char", 32'(char), 32'h61);
        checkOutput("err_busy", 32'(busy), 32'd0);
        applyStimulus(8'h7A, 1'b1);
        waitCycles(10);
        checkOutput("z_cv", cvCount, 2);
        checkOutput("z_char", 32'(char), 32'h7A);
        checkOutput("z_sb_empty", sb.size(), 0);

        // Back-to-back frames with no idle gap.
        applyStimulus(8'h78, 1'b1);
        applyStimulus(8'h31, 1'b1);
        applyStimulus(8'h3F, 1'b1);
        waitCycles(10);
        checkOutput("b2b_cv", cvCount, 5);
        checkOutput("b2b_char", 32'(char), 32'h3F);
        checkOutput("b2b_sb_empty", sb.size(), 0);
        checkOutput("b2b_fe", feCount, 1);

        // Reset in the middle of the data bits of 0x41, then a clean 0x42.
        driveFrame(8'h41, 1'b1, 5);
        checkOutput("busy_mid_data", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_char", 32'(char), 32'h00);
        checkOutput("rst_valid", 32'(char_valid), 32'd0);
        rxd = 1'b1;
        waitCycles(3);
        rst_n = 1'b1;
        waitCycles(10);
        applyStimulus(8'h42, 1'b1);
        waitCycles(100);
        checkOutput("rst_cv", cvCount, 6);
        checkOutput("rst_next_char", 32'(char), 32'h42);
        checkOutput("rst_sb_empty", sb.size(), 0);
        checkOutput("rst_fe", feCount, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
